// File: rtl/vx_issue_ibuffer.sv
// Per-issue-slot instruction buffer: one circular FIFO per warp-in-slot (wis),
// round-robin selection of a head instruction per cycle into a registered
// output stage feeding the scoreboard handshake. Full/empty masks go back to
// the warp scheduler for fetch throttling.
module vx_issue_ibuffer #(
  parameter int NUM_WIS = 4,
  parameter int DEPTH   = 4,
  parameter int DATAW   = 128,
  localparam int WIS_W  = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               decode_valid,
  output logic               decode_ready,
  input  logic [WIS_W-1:0]   decode_wis,
  input  logic [DATAW-1:0]   decode_data,
  output logic               ibuf_valid,
  input  logic               ibuf_ready,
  output logic [WIS_W-1:0]   ibuf_wis,
  output logic [DATAW-1:0]   ibuf_data,
  output logic [NUM_WIS-1:0] full_mask,
  output logic [NUM_WIS-1:0] empty_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WIS_N = 1 << WIS_W;

  // Payload storage, one row per warp, written through a single port
  logic [DATAW-1:0] mem_reg [NUM_WIS][DEPTH];

  // Per-warp state gathered into arrays for indexed access by wis
  logic [CNT_W-1:0] count_all  [NUM_WIS];
  logic [PTR_W-1:0] rd_ptr_all [NUM_WIS];
  logic [PTR_W-1:0] wr_ptr_all [NUM_WIS];

  // Output stage and arbitration state
  logic             out_valid_reg;
  logic [WIS_W-1:0] out_wis_reg;
  logic [DATAW-1:0] out_data_reg;
  logic [WIS_W-1:0] last_grant_reg;

  // Full flags padded to the whole wis code space; unused codes read as full
  // so an out-of-range decode_wis is never accepted.
  logic [WIS_N-1:0] full_ext;

  logic             push;
  logic             load;
  logic             pop;
  logic             sel_found;
  logic [WIS_W-1:0] sel_wis;
  logic [DATAW-1:0] sel_data;

  assign decode_ready = ~full_ext[decode_wis];
  // Pushes are ignored while reset is held, even though decode_ready is live
  assign push = decode_valid && decode_ready && !reset;
  assign load = !out_valid_reg || ibuf_ready;
  assign pop  = load && sel_found;

  assign ibuf_valid = out_valid_reg;
  assign ibuf_wis   = out_wis_reg;
  assign ibuf_data  = out_data_reg;
  assign full_mask  = full_ext[NUM_WIS-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < WIS_N; gi++) begin : g_full
      if (gi < NUM_WIS) begin : g_used
        assign full_ext[gi] = (count_all[gi] == CNT_W'(DEPTH));
      end else begin : g_unused
        assign full_ext[gi] = 1'b1;
      end
    end

    for (gi = 0; gi < NUM_WIS; gi++) begin : g_wis
      logic [CNT_W-1:0] count_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [PTR_W-1:0] wr_ptr_reg;
      logic             push_w;
      logic             pop_w;

      assign push_w = push && (decode_wis == WIS_W'(gi));
      assign pop_w  = pop && (sel_wis == WIS_W'(gi));

      assign count_all[gi]  = count_reg;
      assign rd_ptr_all[gi] = rd_ptr_reg;
      assign wr_ptr_all[gi] = wr_ptr_reg;

      // An instruction is in the queue when counted, or in the output register
      assign empty_mask[gi] = (count_reg == '0) &&
                              !(out_valid_reg && (out_wis_reg == WIS_W'(gi)));

      // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg  <= '0;
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
        end else begin
          if (push_w) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop_w)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          if (push_w && !pop_w)      count_reg <= count_reg + CNT_W'(1);
          else if (!push_w && pop_w) count_reg <= count_reg - CNT_W'(1);
        end
      end
    end
  endgenerate

  // Round-robin pick: first queue with entries after the last granted wis.
  // Uses registered counts only, so a same-edge push is never bypassed.
  always_comb begin
    int idx;
    logic [WIS_W-1:0] idx_w;
    sel_found = 1'b0;
    sel_wis   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 1; i <= NUM_WIS; i++) begin
      idx   = (int'(last_grant_reg) + i) % NUM_WIS;
      idx_w = WIS_W'(idx);
      if (!sel_found && (count_all[idx_w] != '0)) begin
        sel_found = 1'b1;
        sel_wis   = idx_w;
      end
    end
  end

  assign sel_data = mem_reg[sel_wis][rd_ptr_all[sel_wis]];

  // Single write port into the payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[decode_wis][wr_ptr_all[decode_wis]] <= decode_data;
    end
  end

  // Output register: refills whenever empty or being consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      last_grant_reg <= WIS_W'(NUM_WIS - 1);
    end else if (load) begin
      out_valid_reg <= sel_found;
      if (sel_found) begin
        out_wis_reg    <= sel_wis;
        out_data_reg   <= sel_data;
        last_grant_reg <= sel_wis;
      end
    end
  end

endmodule

// File: tb/tb_vx_issue_ibuffer.sv
// Self-checking bench for vx_issue_ibuffer: per-wis scoreboard queues filled on
// decode handshakes and drained on ibuf handshakes, plus directed checks.
module tb_vx_issue_ibuffer;

  localparam int NW = 4;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          decode_valid;
  logic          decode_ready;
  logic [1:0]    decode_wis;
  logic [DW-1:0] decode_data;
  logic          ibuf_valid;
  logic          ibuf_ready;
  logic [1:0]    ibuf_wis;
  logic [DW-1:0] ibuf_data;
  logic [NW-1:0] full_mask;
  logic [NW-1:0] empty_mask;

  int n_checks = 0;
  int n_errors = 0;
  int fire_cnt = 0;

  logic [DW-1:0] exp_q [NW][$];
  int            fire_log [$];

  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic [1:0]    hold_wis;

  int rr_exp [9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};

  always #5 clk = ~clk;

  vx_issue_ibuffer #(.NUM_WIS(NW), .DEPTH(4), .DATAW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .decode_valid (decode_valid),
    .decode_ready (decode_ready),
    .decode_wis   (decode_wis),
    .decode_data  (decode_data),
    .ibuf_valid   (ibuf_valid),
    .ibuf_ready   (ibuf_ready),
    .ibuf_wis     (ibuf_wis),
    .ibuf_data    (ibuf_data),
    .full_mask    (full_mask),
    .empty_mask   (empty_mask)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: scoreboard update at the clock edge (inputs change on negedge)
  always @(posedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", {127'd0, ibuf_valid}, 1);
        check("hold_data", ibuf_data, hold_data);
        check("hold_wis", {126'd0, ibuf_wis}, {126'd0, hold_wis});
      end
      if (ibuf_valid && ibuf_ready) begin
        check("out_expected", {127'd0, exp_q[ibuf_wis].size() > 0}, 1);
        if (exp_q[ibuf_wis].size() > 0) begin
          check("out_data", ibuf_data, exp_q[ibuf_wis].pop_front());
        end
        $display("out wis=%0d data=%h", ibuf_wis, ibuf_data);
        fire_log.push_back(int'(ibuf_wis));
        fire_cnt++;
      end
      if (decode_valid && decode_ready) begin
        exp_q[decode_wis].push_back(decode_data);
      end
      hold_pend = ibuf_valid && !ibuf_ready;
      hold_data = ibuf_data;
      hold_wis  = ibuf_wis;
    end
  end

  task automatic drain(input string tag);
    int k = 0;
    ibuf_ready   = 1'b1;
    decode_valid = 1'b0;
    while (!(ibuf_valid == 1'b0 && empty_mask == 4'hF) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, {127'd0, (ibuf_valid == 1'b0 && empty_mask == 4'hF)}, 1);
  endtask

  initial begin
    logic [DW-1:0] a_data;
    logic [DW-1:0] b0_data;
    logic [DW-1:0] d_data;
    int start_cnt;
    int k;
    int left;

    reset        = 1'b1;
    decode_valid = 1'b0;
    decode_wis   = '0;
    decode_data  = '0;
    ibuf_ready   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_valid", {127'd0, ibuf_valid}, 0);
    check("rst_empty", {124'd0, empty_mask}, 4'hF);
    check("rst_full", {124'd0, full_mask}, 0);
    check("rst_ready", {127'd0, decode_ready}, 1);

    // 1: single push, two-edge latency
    a_data = rnd_data();
    decode_valid = 1'b1; decode_wis = 2'd0; decode_data = a_data;
    @(negedge clk);
    decode_valid = 1'b0;
    check("lat_e1_valid", {127'd0, ibuf_valid}, 0);
    check("lat_e1_empty", {124'd0, empty_mask}, 4'b1110);
    @(negedge clk);
    check("lat_e2_valid", {127'd0, ibuf_valid}, 1);
    check("lat_e2_wis", {126'd0, ibuf_wis}, 0);
    check("lat_e2_data", ibuf_data, a_data);
    check("lat_e2_empty", {124'd0, empty_mask}, 4'b1110);
    @(negedge clk);
    check("lat_e3_valid", {127'd0, ibuf_valid}, 0);
    check("lat_e3_empty", {124'd0, empty_mask}, 4'hF);

    // 2: fill wis2 under backpressure
    ibuf_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      decode_valid = 1'b1; decode_wis = 2'd2; decode_data = rnd_data();
      if (i == 0) b0_data = decode_data;
      @(negedge clk);
    end
    decode_valid = 1'b0;
    check("fill_full", {124'd0, full_mask}, 4'b0100);
    check("fill_empty", {124'd0, empty_mask}, 4'b1011);
    decode_wis = 2'd2; #1;
    check("fill_rdy_w2", {127'd0, decode_ready}, 0);
    decode_wis = 2'd1; #1;
    check("fill_rdy_w1", {127'd0, decode_ready}, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fill_hold_data", ibuf_data, b0_data);
      check("fill_hold_wis", {126'd0, ibuf_wis}, 2);
    end
    drain("fill_drain");

    // 3: round-robin across wis 0,1,3
    ibuf_ready = 1'b0;
    for (int w = 0; w < 4; w++) begin
      if (w == 2) continue;
      for (int i = 0; i < 3; i++) begin
        decode_valid = 1'b1; decode_wis = 2'(w); decode_data = rnd_data();
        @(negedge clk);
      end
    end
    decode_valid = 1'b0;
    fire_log.delete();
    ibuf_ready = 1'b1;
    k = 0;
    while (fire_log.size() < 9 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rr_count", 128'(fire_log.size()), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < fire_log.size()) check("rr_order", 128'(fire_log[i]), 128'(rr_exp[i]));
    end
    drain("rr_drain");

    // 4: streaming push/pop on wis1
    start_cnt = fire_cnt;
    ibuf_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      decode_valid = 1'b1; decode_wis = 2'd1; decode_data = rnd_data();
      #1;
      check("stream_ready", {127'd0, decode_ready}, 1);
      @(negedge clk);
      if (i >= 1) begin
        check("stream_not_empty", {127'd0, empty_mask[1]}, 0);
        check("stream_not_full", {127'd0, full_mask[1]}, 0);
      end
    end
    decode_valid = 1'b0;
    drain("stream_drain");
    check("stream_count", 128'(fire_cnt - start_cnt), 20);

    // 5: random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      ibuf_ready   = 1'($urandom_range(0, 1));
      decode_valid = 1'($urandom_range(0, 1));
      decode_wis   = 2'($urandom_range(0, 3));
      decode_data  = rnd_data();
      @(negedge clk);
    end
    drain("rand_drain");

    // 6: reset mid-operation discards everything
    ibuf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      decode_valid = 1'b1; decode_wis = 2'd0; decode_data = rnd_data();
      @(negedge clk);
    end
    check("pre_rst_valid", {127'd0, ibuf_valid}, 1);
    check("pre_rst_empty", {127'd0, empty_mask[0]}, 0);
    reset = 1'b1;
    decode_valid = 1'b1; decode_wis = 2'd1; decode_data = rnd_data();
    for (int w = 0; w < NW; w++) exp_q[w].delete();
    @(negedge clk);
    reset = 1'b0;
    decode_valid = 1'b0;
    check("post_rst_valid", {127'd0, ibuf_valid}, 0);
    check("post_rst_empty", {124'd0, empty_mask}, 4'hF);
    check("post_rst_full", {124'd0, full_mask}, 0);
    ibuf_ready = 1'b1;
    d_data = rnd_data();
    decode_valid = 1'b1; decode_wis = 2'd0; decode_data = d_data;
    @(negedge clk);
    decode_valid = 1'b0;
    @(negedge clk);
    check("post_rst_gwis", {126'd0, ibuf_wis}, 0);
    check("post_rst_gdata", ibuf_data, d_data);
    drain("final_drain");
    repeat (3) @(negedge clk);

    left = 0;
    for (int w = 0; w < NW; w++) left += exp_q[w].size();
    check("sb_leftover", 128'(left), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vx_issue_ibuffer.md
# vx_issue_ibuffer

Per-issue-slot instruction buffer between decode and the scoreboard stage. It holds one FIFO per warp-in-slot (wis) and selects one head instruction per cycle with round-robin arbitration. The selection goes into a registered output stage that drives the scoreboard's ibuffer input handshake. Per-warp full/empty masks go back to the warp scheduler so it can throttle fetch.

## Interface
- NUM_WIS, 4: warps sharing this issue slot (≥1; wis width WIS_W = max(1, clog2(NUM_WIS)))
- DEPTH, 4: entries per warp FIFO (power of two, ≥2)
- DATAW, 128: opaque instruction payload width (uuid, tmask, PC, ex/op/mod, wb, rd/rs1/rs2/rs3, imm)

- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- decode_valid  in  1  decoded instruction present
- decode_ready  out  1  accept; = ~full_mask[decode_wis]
- decode_wis  in  WIS_W  target warp queue
- decode_data  in  DATAW  payload
- ibuf_valid  out  1  output register holds an instruction
- ibuf_ready  in  1  scoreboard staging buffer accepts
- ibuf_wis  out  WIS_W  wis of output instruction
- ibuf_data  out  DATAW  payload
- full_mask  out  NUM_WIS  queue w holds DEPTH entries
- empty_mask  out  NUM_WIS  queue w holds 0 entries and output register does not hold a wis=w instruction

## Operation
- Per-warp state: circular FIFO storage, rd_ptr/wr_ptr of width clog2(DEPTH) that wrap DEPTH-1→0, count of width clog2(DEPTH+1).
- Push: decode_valid && decode_ready writes at wr_ptr[decode_wis], which then increments.
- Output register (valid, wis, data) loads when `load = ~ibuf_valid || ibuf_ready`. In the same edge it pops the selected queue.
- Selection: a queue is eligible when count>0. Pick the first eligible w scanning last_grant+1, last_grant+2, … (mod NUM_WIS). last_grant updates to the selected w only on an actual pop.
- If load is asserted and no queue is eligible, ibuf_valid goes to 0 at the next edge.
- Push and pop on the same queue in one edge: count unchanged; both pointers advance.
- Push to a full queue cannot occur because decode_ready=0. Pop of an empty queue never occurs.
- No bypass: an instruction is never taken into the output register in the same edge it is pushed.
- Payload is passed bit-exact; order within one wis is strict FIFO. There is no ordering guarantee across wis.
- Reset values:
  - counts=0, pointers=0, last_grant=NUM_WIS-1, so wis 0 has first priority
  - ibuf_valid=0
  - full_mask=0, empty_mask=all ones, decode_ready=1
  - ibuf_data/ibuf_wis are don't-care while ibuf_valid=0
- Reset asserted mid-operation discards all queued and output-register contents. No handshake fires during the reset cycle: decode_ready is still combinational, but pushes are ignored.

## Timing
- Latency: decode fire at edge k → queue nonempty after k → popped into the output register at edge k+1 → ibuf_valid high in cycle k+1..k+2. Minimum is 2 edges, decode to ibuf_valid.
- Throughput: 1 instruction/cycle sustained when any queue is nonempty and ibuf_ready=1.
- ibuf_valid/ibuf_wis/ibuf_data are registered outputs; they are held stable while ibuf_valid && ~ibuf_ready.
- decode_ready is combinational from decode_wis and registered counts. It has no path from ibuf_ready.
- full_mask/empty_mask are derived from registered state only and update the cycle after a push or pop.

## Test plan
- Reset, then push wis0 A at edge 1 with ibuf_ready=1 → ibuf_valid=1, ibuf_wis=0, data=A after edge 2. empty_mask=1111 after reset; empty_mask[0]=0 from edge 1 until A fires.
- Fill wis2 with DEPTH=4 entries while ibuf_ready=0 → the first entry moves to the output register, so 4 more pushes are needed to reach full. full_mask[2]=1 and decode_ready=0 for decode_wis=2, while decode_ready=1 for wis1. Deassert ibuf_ready further → data is held stable.
- Load queues 0,1,3 with 3 entries each, ibuf_ready=1 → output wis sequence 0,1,3,0,1,3,0,1,3; per-wis data stays in push order.
- Continuous push/pop on wis1 with ibuf_ready=1 for 20 cycles → count stays constant, pointers wrap 3→0 without data loss, 20 payloads out in order.
- Random backpressure (ibuf_ready 50%) with random pushes → scoreboard model matches: per-wis order preserved, no drop or duplicate, valid never drops without a fire.
- Assert reset for 1 cycle with 2 entries in wis0 and ibuf_valid=1 → next cycle ibuf_valid=0, empty_mask=1111, and the next grant goes to wis0 first.
